// File: rtl/one_unit_acc.sv
// rtl/one_unit_acc.sv - FastICA one-unit kurtosis update: accumulates z*(w'z)^3 and (w'z)^2
// over 2**LOG2_N samples through one shared 26x26 multiplier, then emits the updated weights.
module one_unit_acc #(
  parameter int LOG2_N = 4,
  parameter int GUARD  = 6
) (
  input  logic        clk_acc,
  input  logic        rst_n_acc,
  input  logic        en_acc,
  input  logic        start,
  input  logic [25:0] w1,
  input  logic [25:0] w2,
  input  logic [25:0] w3,
  input  logic [25:0] w4,
  input  logic [25:0] z1,
  input  logic [25:0] z2,
  input  logic [25:0] z3,
  input  logic [25:0] z4,
  input  logic        z_valid,
  output logic        z_ready,
  output logic [25:0] wn1,
  output logic [25:0] wn2,
  output logic [25:0] wn3,
  output logic [25:0] wn4,
  output logic        done,
  output logic        busy
);
  localparam int W  = 26;
  localparam int YW = W + GUARD;
  localparam int AW = W + LOG2_N + GUARD;
  localparam int CW = LOG2_N + 1;
  localparam int PW = 2 * W;
  localparam int DW = PW - 12;
  localparam int N  = 1 << LOG2_N;

  localparam logic signed [DW-1:0] SAT_MAX = 40'sd33554431;
  localparam logic signed [DW-1:0] SAT_MIN = -40'sd33554432;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DOT, S_CUBE, S_ACC, S_FINAL, S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_step, w_step_nxt;
  logic [CW-1:0]        r_cnt;
  logic signed [W-1:0]  r_z   [4];
  logic signed [W-1:0]  r_wn  [4];
  logic signed [AW-1:0] r_acc [4];
  logic signed [AW-1:0] r_accg;
  logic signed [YW-1:0] r_y;
  logic signed [W-1:0]  r_y2, r_y3;

  logic signed [W-1:0]  w_w [4];
  logic signed [W-1:0]  w_a, w_b, w_y_sat, w_q_sat, w_g3_sat;
  logic signed [PW-1:0] w_prod;
  logic signed [DW-1:0] w_q, w_diff;
  logic signed [AW-1:0] w_mg, w_g3, w_m;

  // Out-of-range Q13 results clamp instead of wrapping, so overflow keeps its sign.
  function automatic logic signed [W-1:0] sat26(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return v[W-1:0];
  endfunction

  assign w_w[0] = $signed(w1);
  assign w_w[1] = $signed(w2);
  assign w_w[2] = $signed(w3);
  assign w_w[3] = $signed(w4);

  assign w_prod   = PW'(w_a) * PW'(w_b);
  assign w_q      = DW'(w_prod >>> 13);
  assign w_q_sat  = sat26(w_q);
  assign w_y_sat  = sat26(DW'(r_y));
  assign w_mg     = r_accg >>> LOG2_N;
  assign w_g3     = w_mg + (w_mg <<< 1);
  assign w_g3_sat = sat26(DW'(w_g3));
  assign w_m      = r_acc[r_step] >>> LOG2_N;
  assign w_diff   = DW'(w_m) - w_q;

  assign z_ready = (r_state == S_WAIT);
  assign done    = (r_state == S_DONE);
  assign busy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign wn1     = r_wn[0];
  assign wn2     = r_wn[1];
  assign wn3     = r_wn[2];
  assign wn4     = r_wn[3];

  always_comb begin
    w_a = '0;
    w_b = '0;
    case (r_state)
      S_DOT: begin
        w_a = w_w[r_step];
        w_b = r_z[r_step];
      end
      S_CUBE: begin
        w_a = (r_step == 2'd0) ? w_y_sat : r_y2;
        w_b = w_y_sat;
      end
      S_ACC: begin
        w_a = r_z[r_step];
        w_b = r_y3;
      end
      S_FINAL: begin
        w_a = w_g3_sat;
        w_b = w_w[r_step];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (!en_acc) begin
      w_state_nxt = S_IDLE;
      w_step_nxt  = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_state_nxt = S_WAIT;
        S_WAIT: if (z_valid) begin
          w_state_nxt = S_DOT;
          w_step_nxt  = 2'd0;
        end
        S_DOT: begin
          w_step_nxt = r_step + 2'd1;
          if (r_step == 2'd3) w_state_nxt = S_CUBE;
        end
        S_CUBE: begin
          w_step_nxt = r_step + 2'd1;
          if (r_step == 2'd1) begin
            w_state_nxt = S_ACC;
            w_step_nxt  = 2'd0;
          end
        end
        S_ACC: begin
          w_step_nxt = r_step + 2'd1;
          if (r_step == 2'd3)
            w_state_nxt = (r_cnt == CW'(N - 1)) ? S_FINAL : S_WAIT;
        end
        S_FINAL: begin
          w_step_nxt = r_step + 2'd1;
          if (r_step == 2'd3) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_acc or negedge rst_n_acc) begin
    if (!rst_n_acc) begin
      r_state <= S_IDLE;
      r_step  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_ff @(posedge clk_acc or negedge rst_n_acc) begin
    if (!rst_n_acc) begin
      for (int i = 0; i < 4; i++) begin
        r_z[i]   <= '0;
        r_acc[i] <= '0;
        r_wn[i]  <= '0;
      end
      r_accg <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_y2   <= '0;
      r_y3   <= '0;
    end else if (en_acc) begin
      case (r_state)
        S_IDLE: if (start) begin
          for (int i = 0; i < 4; i++) r_acc[i] <= '0;
          r_accg <= '0;
          r_cnt  <= '0;
        end
        S_WAIT: if (z_valid) begin
          r_z[0] <= $signed(z1);
          r_z[1] <= $signed(z2);
          r_z[2] <= $signed(z3);
          r_z[3] <= $signed(z4);
          r_y    <= '0;
        end
        S_DOT: r_y <= r_y + YW'(w_q_sat);
        S_CUBE: begin
          if (r_step == 2'd0) r_y2 <= w_q_sat;
          else                r_y3 <= w_q_sat;
        end
        S_ACC: begin
          r_acc[r_step] <= r_acc[r_step] + AW'(w_q_sat);
          if (r_step == 2'd0) r_accg <= r_accg + AW'(r_y2);
          if (r_step == 2'd3) r_cnt  <= r_cnt + CW'(1);
        end
        S_FINAL: r_wn[r_step] <= sat26(w_diff);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_one_unit_acc.sv
// tb/tb_one_unit_acc.sv - directed self-checking bench for one_unit_acc
module tb_one_unit_acc;
  logic        clk_acc = 1'b0;
  logic        rst_n_acc, en_acc, start, z_valid;
  logic [25:0] w1, w2, w3, w4, z1, z2, z3, z4;
  logic        z_ready, done, busy;
  logic [25:0] wn1, wn2, wn3, wn4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cstart = 0;
  int done_cnt = 0;
  int zr_bad = 0;
  int lat;

  one_unit_acc #(.LOG2_N(4), .GUARD(6)) dut (
    .clk_acc(clk_acc), .rst_n_acc(rst_n_acc), .en_acc(en_acc), .start(start),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4),
    .z_valid(z_valid), .z_ready(z_ready),
    .wn1(wn1), .wn2(wn2), .wn3(wn3), .wn4(wn4),
    .done(done), .busy(busy)
  );

  always #5 clk_acc = ~clk_acc;
  always @(posedge clk_acc) cyc <= cyc + 1;
  always @(posedge clk_acc) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_w(input logic [3:0][25:0] wv);
    w1 = wv[0]; w2 = wv[1]; w3 = wv[2]; w4 = wv[3];
  endtask

  task automatic do_start();
    @(negedge clk_acc);
    start = 1'b1;
    @(negedge clk_acc);
    start = 1'b0;
    cstart = cyc;
  endtask

  // After each handshake the block is occupied for 10 cycles with z_ready low.
  task automatic feed(input logic [3:0][25:0] zv, input int n, input bit stalls);
    for (int s = 0; s < n; s++) begin
      int guard;
      if (stalls) repeat ($urandom_range(0, 7)) @(negedge clk_acc);
      z1 = zv[0]; z2 = zv[1]; z3 = zv[2]; z4 = zv[3];
      z_valid = 1'b1;
      guard = 0;
      while (!z_ready && guard < 50) begin
        @(negedge clk_acc);
        guard++;
      end
      if (!z_ready) begin
        check("z_ready_timeout", 0, 1);
        z_valid = 1'b0;
        return;
      end
      @(posedge clk_acc);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk_acc);
        z_valid = 1'b0;
        if (z_ready) zr_bad++;
      end
    end
  endtask

  task automatic wait_done(output int l);
    int guard = 0;
    l = -1;
    while (!done && guard < 400) begin
      @(negedge clk_acc);
      guard++;
    end
    if (!done) check("done_timeout", 0, 1);
    else l = cyc - cstart;
  endtask

  task automatic run(input logic [3:0][25:0] wv, input logic [3:0][25:0] zv, input bit stalls,
                     output int l);
    set_w(wv);
    do_start();
    check("busy_after_start", busy, 1);
    feed(zv, 16, stalls);
    wait_done(l);
    @(negedge clk_acc);
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_wn(input string tag, input longint e1, input longint e2,
                          input longint e3, input longint e4);
    check({tag, "_wn1"}, $signed(wn1), e1);
    check({tag, "_wn2"}, $signed(wn2), e2);
    check({tag, "_wn3"}, $signed(wn3), e3);
    check({tag, "_wn4"}, $signed(wn4), e4);
  endtask

  localparam logic [25:0] ONE  = 26'd8192;
  localparam logic [25:0] HALF = 26'd4096;
  localparam logic [25:0] WMAX = 26'd33554431;

  initial begin
    int d0;
    rst_n_acc = 1'b0; en_acc = 1'b1; start = 1'b0; z_valid = 1'b0;
    w1 = '0; w2 = '0; w3 = '0; w4 = '0;
    z1 = '0; z2 = '0; z3 = '0; z4 = '0;
    repeat (3) @(negedge clk_acc);
    check_wn("rst", 0, 0, 0, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_zready", z_ready, 0);
    rst_n_acc = 1'b1;
    repeat (4) @(negedge clk_acc);
    check("idle_busy", busy, 0);
    check("idle_zready", z_ready, 0);

    // Start accepted at edge S; sample k handshakes at S+1+11k, FINAL at S+176, done at S+180.
    run({26'd0, 26'd0, 26'd0, ONE}, {26'd0, 26'd0, 26'd0, ONE}, 1'b0, lat);
    check("unit_latency", lat, 180);
    check_wn("unit", -16384, 0, 0, 0);
    check("unit_busy_idle", busy, 0);

    // y=4096, y2=2048, y3=1024, m1=512, g3=6144
    run({26'd0, 26'd0, 26'd0, ONE}, {26'd0, 26'd0, 26'd0, HALF}, 1'b0, lat);
    check_wn("half", -5632, 0, 0, 0);

    // y=8192, y3=8192, m=4096, g3=24576, g3*w=12288 in every lane
    run({HALF, HALF, HALF, HALF}, {HALF, HALF, HALF, HALF}, 1'b0, lat);
    check_wn("lanes", -8192, -8192, -8192, -8192);

    run({26'd0, 26'd0, 26'd0, ONE}, {26'd0, 26'd0, 26'd0, ONE}, 1'b1, lat);
    check_wn("stall", -16384, 0, 0, 0);
    check("zready_outside_wait", zr_bad, 0);

    // Abort a half-case run after 5 samples; wn must keep the stalled-run result.
    set_w({26'd0, 26'd0, 26'd0, ONE});
    do_start();
    feed({26'd0, 26'd0, 26'd0, HALF}, 5, 1'b0);
    d0 = done_cnt;
    en_acc = 1'b0;
    @(negedge clk_acc);
    check("abort_busy", busy, 0);
    check("abort_zready", z_ready, 0);
    repeat (20) @(negedge clk_acc);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_wn1_kept", $signed(wn1), -16384);
    en_acc = 1'b1;
    run({26'd0, 26'd0, 26'd0, ONE}, {26'd0, 26'd0, 26'd0, ONE}, 1'b0, lat);
    check_wn("after_abort", -16384, 0, 0, 0);

    // y, y2, y3 clamp to max; the g3*w1 term is far larger than m1, so wn1 clamps low.
    run({26'd0, 26'd0, 26'd0, WMAX}, {26'd0, 26'd0, 26'd0, ONE}, 1'b0, lat);
    check_wn("sat", -33554432, 0, 0, 0);

    // Reset in the last ACC cycle of the second sample.
    set_w({26'd0, 26'd0, 26'd0, ONE});
    do_start();
    feed({26'd0, 26'd0, 26'd0, ONE}, 2, 1'b0);
    rst_n_acc = 1'b0;
    #1;
    check("midrst_wn1", $signed(wn1), 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_zready", z_ready, 0);
    @(negedge clk_acc);
    rst_n_acc = 1'b1;
    repeat (5) @(negedge clk_acc);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_zready", z_ready, 0);
    run({26'd0, 26'd0, 26'd0, ONE}, {26'd0, 26'd0, 26'd0, ONE}, 1'b0, lat);
    check_wn("post_rst", -16384, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
